// File: rtl/memorio_bridge.sv
// memorio_bridge
//   Bridge between the CPU datapath and memory / memory-mapped IO.
//   Memory accesses pass straight through and never stall. IO accesses are
//   decoded to one of NCH address windows. The request is latched, held for
//   WAIT wait states, and then completes when the channel raises ready.
//   An unmapped address, or a channel that does not respond within TIMEOUT
//   cycles, raises a sticky bus error instead of hanging the core.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   caddress    address from ALU result
//   memread     memory load strobe
//   memwrite    memory store strobe
//   ioread      IO load strobe
//   iowrite     IO store strobe
//   mread_data  memory read data
//   wdata       store data from decode
//   io_rdata    per-channel read data, channel k at [k*IOW +: IOW]
//   io_ready    per-channel ready
//   err_clr     clears bus_err
//   address     address to memory/IO
//   write_data  data to memory/IO (0 when no store is driven)
//   rdata       load data to register file
//   io_cs       one-hot channel select
//   io_rd       IO read strobe
//   io_wr       IO write strobe
//   stall       CPU hold request
//   bus_err     sticky error flag
//   err_addr    address of first faulting access
module memorio_bridge #(
    parameter int          NCH      = 4,
    parameter logic [31:0] IO_BASE  = 32'hFFFFFC60,
    parameter int          WIN_BITS = 4,
    parameter int          IOW      = 16,
    parameter int          WAIT     = 2,
    parameter int          TIMEOUT  = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        caddress,
    input  logic               memread,
    input  logic               memwrite,
    input  logic               ioread,
    input  logic               iowrite,
    input  logic [31:0]        mread_data,
    input  logic [31:0]        wdata,
    input  logic [NCH*IOW-1:0] io_rdata,
    input  logic [NCH-1:0]     io_ready,
    input  logic               err_clr,
    output logic [31:0]        address,
    output logic [31:0]        write_data,
    output logic [31:0]        rdata,
    output logic [NCH-1:0]     io_cs,
    output logic               io_rd,
    output logic               io_wr,
    output logic               stall,
    output logic               bus_err,
    output logic [31:0]        err_addr
);

    localparam int          CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT);
    localparam logic [7:0]  TMO_LD  = 8'(TIMEOUT);
    localparam logic [31:0] BASE_IX = IO_BASE >> WIN_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic [CHW-1:0] ch_q;
    logic           dir_wr_q;
    logic [3:0]     wait_cnt;
    logic [7:0]     tmo_cnt;
    logic [31:0]    rd_reg;

    logic           io_req;
    logic           hit;
    logic [CHW-1:0] hit_ch;
    logic           start;
    logic           capture;
    logic           err_evt;
    logic [31:0]    cap_data;

    // Memory strobes take priority; an IO strobe alongside one is ignored.
    assign io_req = (ioread | iowrite) & ~(memread | memwrite);

    // Window decode: channel k owns caddress[31:WIN_BITS] == BASE_IX + k.
    always_comb begin
        hit    = 1'b0;
        hit_ch = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if ((caddress >> WIN_BITS) == (BASE_IX + 32'(k))) begin
                hit    = 1'b1;
                hit_ch = CHW'(k);
            end
        end
    end

    // Read data of the latched channel, zero-extended to 32 bits.
    always_comb begin
        cap_data           = '0;
        cap_data[IOW-1:0]  = io_rdata[ch_q*IOW +: IOW];
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, plus the single-cycle events that drive the datapath
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        err_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (io_req) begin
                    if (hit) begin
                        start     = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) begin
                    if (io_ready[ch_q]) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else if (tmo_cnt == '0) begin
                        err_evt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        io_cs = '0;
        if (state == ACCESS) begin
            io_cs[ch_q] = 1'b1;
        end
        io_rd = (state == ACCESS) & ~dir_wr_q;
        io_wr = (state == ACCESS) &  dir_wr_q;

        // Held low while reset is asserted so the CPU is released at once
        // when an access is aborted.
        stall = io_req & (state != DONE) & reset;

        address = (state == ACCESS) ? lat_addr : caddress;

        if (memwrite) begin
            write_data = wdata;
        end else if ((state == ACCESS) && dir_wr_q) begin
            write_data = lat_wdata;
        end else begin
            write_data = '0;
        end

        rdata = memread ? mread_data : rd_reg;
    end

    // Request latch and wait/timeout counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            ch_q      <= '0;
            dir_wr_q  <= 1'b0;
            wait_cnt  <= '0;
            tmo_cnt   <= '0;
        end else if (start) begin
            lat_addr  <= caddress;
            lat_wdata <= wdata;
            ch_q      <= hit_ch;
            dir_wr_q  <= iowrite;
            wait_cnt  <= WAIT_LD;
            tmo_cnt   <= TMO_LD;
        end else if (state == ACCESS) begin
            if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else if (!io_ready[ch_q] && (tmo_cnt != '0)) begin
                tmo_cnt <= tmo_cnt - 8'd1;
            end
        end
    end

    // Read register: channel data on a completed read, zero on a completed
    // write or on any error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_reg <= '0;
        end else if (capture) begin
            rd_reg <= dir_wr_q ? '0 : cap_data;
        end else if (err_evt) begin
            rd_reg <= '0;
        end
    end

    // Sticky error; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (err_evt) begin
            bus_err <= 1'b1;
            if (!bus_err) begin
                err_addr <= (state == ACCESS) ? lat_addr : caddress;
            end
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memorio_bridge.sv
`timescale 1ns/1ps
module tb_memorio_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] caddress;
    logic        memread, memwrite, ioread, iowrite;
    logic [31:0] mread_data;
    logic [31:0] wdata;
    logic [63:0] io_rdata;
    logic [3:0]  io_ready;
    logic        err_clr;
    logic [31:0] address, write_data, rdata, err_addr;
    logic [3:0]  io_cs;
    logic        io_rd, io_wr, stall, bus_err;

    int checks = 0;
    int errors = 0;

    memorio_bridge #(
        .NCH     (4),
        .IO_BASE (32'hFFFFFC60),
        .WIN_BITS(4),
        .IOW     (16),
        .WAIT    (2),
        .TIMEOUT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .caddress  (caddress),
        .memread   (memread),
        .memwrite  (memwrite),
        .ioread    (ioread),
        .iowrite   (iowrite),
        .mread_data(mread_data),
        .wdata     (wdata),
        .io_rdata  (io_rdata),
        .io_ready  (io_ready),
        .err_clr   (err_clr),
        .address   (address),
        .write_data(write_data),
        .rdata     (rdata),
        .io_cs     (io_cs),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .stall     (stall),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; caddress = '0; memread = 0; memwrite = 0; ioread = 0; iowrite = 0;
        mread_data = '0; wdata = '0; io_rdata = '0; io_ready = '0; err_clr = 0;

        // ---------------- reset values
        #12;
        chk("rst_io_cs", 32'(io_cs), 32'h0);
        chk("rst_io_rd", 32'(io_rd), 32'h0);
        chk("rst_io_wr", 32'(io_wr), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // ---------------- ch1 read, ready already high
        cyc;
        caddress = 32'hFFFFFC74; ioread = 1;
        io_rdata = 64'h0000_0000_A5A5_0000; io_ready = 4'b1111;
        #1;
        chk("rd_c0_stall", 32'(stall), 32'h1);
        chk("rd_c0_cs", 32'(io_cs), 32'h0);
        cyc;
        caddress = 32'hFFFFFC60;              // ignored during ACCESS
        #1;
        chk("rd_c1_stall", 32'(stall), 32'h1);
        chk("rd_c1_cs", 32'(io_cs), 32'h2);
        chk("rd_c1_io_rd", 32'(io_rd), 32'h1);
        chk("rd_c1_addr", address, 32'hFFFFFC74);
        cyc; #1;
        chk("rd_c2_stall", 32'(stall), 32'h1);
        chk("rd_c2_cs", 32'(io_cs), 32'h2);
        cyc; caddress = 32'hFFFFFC74; #1;
        chk("rd_c3_stall", 32'(stall), 32'h1);
        chk("rd_c3_cs", 32'(io_cs), 32'h2);
        cyc; #1;
        chk("rd_c4_stall", 32'(stall), 32'h0);
        chk("rd_c4_cs", 32'(io_cs), 32'h0);
        chk("rd_c4_rdata", rdata, 32'h0000A5A5);
        ioread = 0;

        // ---------------- ch0 write
        cyc;
        caddress = 32'hFFFFFC60; iowrite = 1; wdata = 32'h12345678;
        #1;
        chk("wr_c0_stall", 32'(stall), 32'h1);
        chk("wr_c0_io_wr", 32'(io_wr), 32'h0);
        chk("wr_c0_wdata", write_data, 32'h0);
        cyc;
        wdata = 32'h0;                        // latched copy must be driven
        #1;
        for (int i = 1; i <= 3; i++) begin
            chk("wr_io_wr", 32'(io_wr), 32'h1);
            chk("wr_cs", 32'(io_cs), 32'h1);
            chk("wr_wdata", write_data, 32'h12345678);
            chk("wr_io_rd", 32'(io_rd), 32'h0);
            cyc; #1;
        end
        chk("wr_c4_stall", 32'(stall), 32'h0);
        chk("wr_c4_io_wr", 32'(io_wr), 32'h0);
        chk("wr_c4_rdata", rdata, 32'h0);
        iowrite = 0;

        // ---------------- unmapped read
        cyc;
        caddress = 32'hFFFFFD00; ioread = 1;
        #1;
        chk("miss_c0_stall", 32'(stall), 32'h1);
        chk("miss_c0_io_rd", 32'(io_rd), 32'h0);
        chk("miss_c0_bus_err", 32'(bus_err), 32'h0);
        cyc; #1;
        chk("miss_c1_stall", 32'(stall), 32'h0);
        chk("miss_c1_bus_err", 32'(bus_err), 32'h1);
        chk("miss_c1_err_addr", err_addr, 32'hFFFFFD00);
        chk("miss_c1_rdata", rdata, 32'h0);
        chk("miss_c1_cs", 32'(io_cs), 32'h0);
        ioread = 0;
        cyc;
        caddress = 32'hFFFFFD10; ioread = 1;
        cyc; #1;
        chk("miss2_bus_err", 32'(bus_err), 32'h1);
        chk("miss2_err_addr", err_addr, 32'hFFFFFD00);
        ioread = 0;
        cyc; err_clr = 1;
        cyc; err_clr = 0; #1;
        chk("clr_bus_err", 32'(bus_err), 32'h0);
        // error and clear together: error wins, address reloaded
        caddress = 32'hFFFFFE00; ioread = 1; err_clr = 1;
        cyc; err_clr = 0; #1;
        chk("errwin_bus_err", 32'(bus_err), 32'h1);
        chk("errwin_err_addr", err_addr, 32'hFFFFFE00);
        ioread = 0;
        cyc; err_clr = 1;
        cyc; err_clr = 0; #1;
        chk("clr2_bus_err", 32'(bus_err), 32'h0);

        // ---------------- ch2 timeout (TIMEOUT=8 -> DONE at cycle 12)
        io_rdata = 64'h0000_BEEF_A5A5_0000; io_ready = 4'b1011;
        cyc;
        caddress = 32'hFFFFFC80; ioread = 1;
        #1;
        chk("to_c0_stall", 32'(stall), 32'h1);
        for (int i = 1; i <= 11; i++) begin
            cyc; #1;
            chk("to_stall", 32'(stall), 32'h1);
            chk("to_cs", 32'(io_cs), 32'h4);
        end
        cyc; #1;
        chk("to_c12_stall", 32'(stall), 32'h0);
        chk("to_c12_bus_err", 32'(bus_err), 32'h1);
        chk("to_c12_err_addr", err_addr, 32'hFFFFFC80);
        chk("to_c12_rdata", rdata, 32'h0);
        ioread = 0;
        cyc; err_clr = 1;
        cyc; err_clr = 0; #1;
        chk("clr3_bus_err", 32'(bus_err), 32'h0);

        // ---------------- ch2, ready rises in cycle 6
        caddress = 32'hFFFFFC80; ioread = 1;
        #1;
        chk("rr_c0_stall", 32'(stall), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            cyc;
        end
        cyc;
        io_ready = 4'b1111;
        #1;
        chk("rr_c6_stall", 32'(stall), 32'h1);
        cyc; #1;
        chk("rr_c7_stall", 32'(stall), 32'h0);
        chk("rr_c7_bus_err", 32'(bus_err), 32'h0);
        chk("rr_c7_rdata", rdata, 32'h0000BEEF);
        ioread = 0;

        // ---------------- memory priority
        cyc;
        caddress = 32'hFFFFFC74; memread = 1; ioread = 1; mread_data = 32'hCAFEF00D;
        #1;
        chk("mem_stall", 32'(stall), 32'h0);
        chk("mem_rdata", rdata, 32'hCAFEF00D);
        chk("mem_cs", 32'(io_cs), 32'h0);
        cyc; #1;
        chk("mem_c1_cs", 32'(io_cs), 32'h0);
        chk("mem_c1_stall", 32'(stall), 32'h0);
        memread = 0; ioread = 0; memwrite = 1; iowrite = 1; wdata = 32'h11223344;
        #1;
        chk("memw_wdata", write_data, 32'h11223344);
        chk("memw_stall", 32'(stall), 32'h0);
        cyc; #1;
        chk("memw_c1_io_wr", 32'(io_wr), 32'h0);
        memwrite = 0; iowrite = 0;

        // ---------------- reset during ACCESS
        cyc;
        caddress = 32'hFFFFFC74; ioread = 1;
        cyc; cyc; #1;
        chk("ra_c2_cs", 32'(io_cs), 32'h2);
        reset = 1'b0;
        #1;
        chk("ra_cs", 32'(io_cs), 32'h0);
        chk("ra_io_rd", 32'(io_rd), 32'h0);
        chk("ra_stall", 32'(stall), 32'h0);
        @(negedge clock);
        reset = 1'b1; ioread = 0;
        cyc;
        caddress = 32'hFFFFFC74; ioread = 1;
        #1;
        chk("ra2_c0_stall", 32'(stall), 32'h1);
        cyc; cyc; cyc; #1;
        chk("ra2_c3_cs", 32'(io_cs), 32'h2);
        cyc; #1;
        chk("ra2_c4_stall", 32'(stall), 32'h0);
        chk("ra2_c4_rdata", rdata, 32'h0000A5A5);
        chk("ra2_c4_bus_err", 32'(bus_err), 32'h0);
        ioread = 0;

        cyc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
